// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle RV32I core: decode inputs,
// memory handshake and every control strobe.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] memtoreg;
  logic [1:0] alusrc_a;
  logic [1:0] alusrc_b;
  logic [2:0] aluop;
  logic       instr_done;
  logic       illegal;
  logic       bus_error;
  logic [3:0] state;

  // Control unit side.
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           memtoreg, alusrc_a, alusrc_b, aluop, instr_done, illegal, bus_error, state
  );

  // Datapath side.
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           memtoreg, alusrc_a, alusrc_b, aluop, instr_done, illegal, bus_error, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV32I datapath with memory ready handshake,
// wait-state watchdog and sticky trap.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWb   = 4'd6,
    StMemWr   = 4'd7,
    StBranch  = 4'd8,
    StJal     = 4'd9,
    StLui     = 4'd10,
    StAluWb   = 4'd11,
    StTrap    = 4'd12
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_error_q, bus_error_d;
  logic            in_mem;
  logic            timeout;

  assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A ready arriving in the limit cycle wins: the access completes instead of trapping.
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !bus.mem_ready &&
                   (wait_q == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    wait_d      = '0;
    case (state_q)
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpLoad, OpStore: state_d = StMemAddr;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExecR, StExecI, StLui: state_d = StAluWb;
      StMemAddr: state_d = (bus.opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StMemWb, StBranch, StJal, StAluWb: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
    if (timeout) begin
      state_d     = StTrap;
      bus_error_d = 1'b1;
    end else if (in_mem && !bus.mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.memtoreg   = 2'b00;
    bus.alusrc_a   = 2'b00;
    bus.alusrc_b   = 2'b00;
    bus.aluop      = 3'b000;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.bus_error  = 1'b0;
    bus.state      = 4'd0;
    if (!rst) begin
      bus.illegal   = illegal_q;
      bus.bus_error = bus_error_q;
      bus.state     = state_q;
      case (state_q)
        StFetch: begin
          bus.mem_read = 1'b1;
          bus.alusrc_b = 2'b10;
          bus.aluop    = 3'b111;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        StDecode: begin
          bus.alusrc_b = 2'b01;
          bus.aluop    = 3'b111;
        end
        StExecR: begin
          bus.alusrc_a = 2'b01;
          bus.aluop    = 3'b000;
        end
        StExecI: begin
          bus.alusrc_a = 2'b01;
          bus.alusrc_b = 2'b01;
          bus.aluop    = 3'b001;
        end
        StMemAddr: begin
          bus.alusrc_a = 2'b01;
          bus.alusrc_b = 2'b01;
          bus.aluop    = (bus.opcode == OpStore) ? 3'b011 : 3'b010;
        end
        StMemRd: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        StMemWb: begin
          bus.reg_write  = 1'b1;
          bus.memtoreg   = 2'b01;
          bus.instr_done = 1'b1;
        end
        StMemWr: begin
          bus.mem_write  = 1'b1;
          bus.iord       = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        StBranch: begin
          bus.alusrc_a   = 2'b01;
          bus.aluop      = 3'b100;
          bus.pc_src     = 2'b01;
          bus.pc_write   = bus.zero;
          bus.instr_done = 1'b1;
        end
        StJal: begin
          bus.reg_write  = 1'b1;
          bus.memtoreg   = 2'b10;
          bus.pc_src     = 2'b01;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        StLui: begin
          bus.alusrc_a = 2'b10;
          bus.alusrc_b = 2'b01;
          bus.aluop    = 3'b110;
        end
        StAluWb: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle vectors for multicycle_control with a short watchdog limit.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst;

  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
  //  memtoreg, alusrc_a, alusrc_b, aluop, instr_done, illegal, bus_error}
  localparam logic [23:0] E_RST = 24'h000000;
  localparam logic [23:0] E_FW  = {4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                   2'b00, 2'b00, 2'b10, 3'b111, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_FR  = {4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                   2'b00, 2'b00, 2'b10, 3'b111, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_DEC = {4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b00, 2'b01, 3'b111, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_XR  = {4'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_XI  = {4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_MAL = {4'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_MAS = {4'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b01, 3'b011, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_MRD = {4'd5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                   2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_MWB = {4'd6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_WRW = {4'd7, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                   2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_WRR = {4'd7, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                   2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_BRT = {4'd8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_BRN = {4'd8, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b01, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_JAL = {4'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   2'b10, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_LUI = {4'd10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b00, 2'b10, 2'b01, 3'b110, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] E_AWB = {4'd11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] E_TRI = 24'hC00002;
  localparam logic [23:0] E_TRB = 24'hC00001;

  localparam logic [6:0] OR  = 7'b0110011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] OL  = 7'b0000011;
  localparam logic [6:0] OS  = 7'b0100011;
  localparam logic [6:0] OB  = 7'b1100011;
  localparam logic [6:0] OJ  = 7'b1101111;
  localparam logic [6:0] OU  = 7'b0110111;
  localparam logic [6:0] OX  = 7'b1110011;

  typedef struct {
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        rdy;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rd,
                     input logic [23:0] e, input string nm);
    vec_t v;
    v.rst = r; v.opcode = op; v.zero = z; v.rdy = rd; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then step the clock.
  task automatic apply(input logic r, input logic [6:0] op, input logic z, input logic rd,
                       input logic [23:0] e, input string nm);
    logic [23:0] got;
    rst           = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rd;
    @(negedge clk);
    got = {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
           bus.mem_write, bus.reg_write, bus.memtoreg, bus.alusrc_a, bus.alusrc_b,
           bus.aluop, bus.instr_done, bus.illegal, bus.bus_error};
    applied++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    add(1, OR, 0, 1, E_RST, "reset");
    // R-type, ready tied high: 4 cycles
    add(0, OR, 0, 1, E_FR,  "r_fetch");
    add(0, OR, 0, 1, E_DEC, "r_decode");
    add(0, OR, 0, 1, E_XR,  "r_exec");
    add(0, OR, 0, 1, E_AWB, "r_wb");
    // I-type
    add(0, OI, 0, 1, E_FR,  "i_fetch");
    add(0, OI, 0, 1, E_DEC, "i_decode");
    add(0, OI, 0, 1, E_XI,  "i_exec");
    add(0, OI, 0, 1, E_AWB, "i_wb");
    // LUI
    add(0, OU, 0, 1, E_FR,  "lui_fetch");
    add(0, OU, 0, 1, E_DEC, "lui_decode");
    add(0, OU, 0, 1, E_LUI, "lui_exec");
    add(0, OU, 0, 1, E_AWB, "lui_wb");
    // Load with three wait states in MEM_RD: 8 cycles
    add(0, OL, 0, 1, E_FR,  "ld_fetch");
    add(0, OL, 0, 1, E_DEC, "ld_decode");
    add(0, OL, 0, 1, E_MAL, "ld_addr");
    add(0, OL, 0, 0, E_MRD, "ld_wait1");
    add(0, OL, 0, 0, E_MRD, "ld_wait2");
    add(0, OL, 0, 0, E_MRD, "ld_wait3");
    add(0, OL, 0, 1, E_MRD, "ld_rd_done");
    add(0, OL, 0, 1, E_MWB, "ld_wb");
    // Store with one wait state
    add(0, OS, 0, 1, E_FR,  "st_fetch");
    add(0, OS, 0, 1, E_DEC, "st_decode");
    add(0, OS, 0, 1, E_MAS, "st_addr");
    add(0, OS, 0, 0, E_WRW, "st_wait");
    add(0, OS, 0, 1, E_WRR, "st_done");
    // Branch taken, then not taken
    add(0, OB, 1, 1, E_FR,  "bt_fetch");
    add(0, OB, 1, 1, E_DEC, "bt_decode");
    add(0, OB, 1, 1, E_BRT, "bt_branch");
    add(0, OB, 0, 1, E_FR,  "bn_fetch");
    add(0, OB, 0, 1, E_DEC, "bn_decode");
    add(0, OB, 0, 1, E_BRN, "bn_branch");
    // JAL after two fetch wait states
    add(0, OJ, 0, 0, E_FW,  "jal_fwait1");
    add(0, OJ, 0, 0, E_FW,  "jal_fwait2");
    add(0, OJ, 0, 1, E_FR,  "jal_fetch");
    add(0, OJ, 0, 1, E_DEC, "jal_decode");
    add(0, OJ, 0, 1, E_JAL, "jal_exec");
    // Illegal opcode traps
    add(0, OX, 0, 1, E_FR,  "ill_fetch");
    add(0, OX, 0, 1, E_DEC, "ill_decode");
    add(0, OX, 0, 1, E_TRI, "ill_trap");
    add(1, OX, 0, 1, E_RST, "ill_reset");
    // Watchdog: four low cycles in FETCH trap
    add(0, OR, 0, 0, E_FW,  "wd_wait1");
    add(0, OR, 0, 0, E_FW,  "wd_wait2");
    add(0, OR, 0, 0, E_FW,  "wd_wait3");
    add(0, OR, 0, 0, E_FW,  "wd_wait4");
    add(0, OR, 0, 0, E_TRB, "wd_trap");
    add(0, OR, 0, 1, E_TRB, "wd_trap_hold");
    add(1, OR, 0, 0, E_RST, "wd_reset");
    // Ready on the fourth cycle wins over the limit
    add(0, OR, 0, 0, E_FW,  "wd_ok_wait1");
    add(0, OR, 0, 0, E_FW,  "wd_ok_wait2");
    add(0, OR, 0, 0, E_FW,  "wd_ok_wait3");
    add(0, OR, 0, 1, E_FR,  "wd_ok_ready");
    add(0, OR, 0, 1, E_DEC, "wd_ok_decode");
    add(1, OR, 0, 1, E_RST, "wd_ok_reset");

    @(posedge clk);
    #1;
    foreach (vecs[i])
      apply(vecs[i].rst, vecs[i].opcode, vecs[i].zero, vecs[i].rdy, vecs[i].exp, vecs[i].name);

    // Illegal trap is silent and sticky for 20 cycles, then reset clears it
    apply(0, OX, 0, 1, E_FR,  "trap20_fetch");
    apply(0, OX, 0, 1, E_DEC, "trap20_decode");
    for (int k = 0; k < 20; k++) apply(0, OR, 1, k[0], E_TRI, "trap20_hold");
    apply(1, OR, 0, 0, E_RST, "trap20_reset");
    apply(0, OR, 0, 0, E_FW,  "trap20_refetch");
    apply(0, OR, 0, 1, E_FR,  "trap20_refetch_rdy");

    // Reset in the middle of a load read drops outputs that same cycle
    apply(0, OL, 0, 1, E_DEC, "mid_decode");
    apply(0, OL, 0, 0, E_MAL, "mid_addr");
    apply(0, OL, 0, 0, E_MRD, "mid_wait");
    apply(1, OL, 0, 0, E_RST, "mid_reset");
    apply(0, OL, 0, 0, E_FW,  "mid_restart");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences a multi-cycle RV32I datapath: shared instruction/data memory, IR, A/B/ALUOut registers, single ALU.
- Replaces the single-cycle decode for the multi-cycle core. Reuses the same opcode set and aluop encoding.
- Adds a memory ready handshake, a timeout watchdog and a sticky trap state.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles for mem_ready in any memory state; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; stable from DECODE until the instruction retires
- zero  in  1  ALU branch-taken flag, valid in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00=ALU result, 01=ALUOut register
- ir_write  out  1  IR load enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- memtoreg  out  2  writeback select: 00=ALUOut, 01=MDR, 10=PC
- alusrc_a  out  2  ALU A select: 00=PC, 01=A reg, 10=zero
- alusrc_b  out  2  ALU B select: 00=B reg, 01=imm, 10=const 4
- aluop  out  3  000 R, 001 I, 010 load, 011 store, 100 branch, 101 JAL, 110 LUI, 111 forced add
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction
- illegal  out  1  sticky: unsupported opcode decoded
- bus_error  out  1  sticky: memory timeout
- state  out  4  current state encoding, for debug

Behaviour:
- Reset: state←FETCH, wait counter←0, illegal←0, bus_error←0. While rst is high, every output is 0.
- Default for all outputs is 0 unless listed for the state. Unused mux selects are 00.
- FETCH (0):
  - mem_read=1, iord=0, alusrc_a=00, alusrc_b=10, aluop=111, pc_src=00.
  - ir_write=1 and pc_write=1 only in a cycle where mem_ready=1; then go to DECODE. Otherwise hold FETCH.
- DECODE (1): alusrc_a=00, alusrc_b=01, aluop=111, so ALUOut←PC+imm. PC already holds PC+4 here, so the target is relative to PC+4. Dispatch on opcode:
  - 0110011→EXEC_R
  - 0010011→EXEC_I
  - 0000011 or 0100011→MEM_ADDR
  - 1100011→BRANCH
  - 1101111→JAL
  - 0110111→LUI
  - any other opcode→TRAP, with illegal←1
- EXEC_R (2): alusrc_a=01, alusrc_b=00, aluop=000 → ALU_WB.
- EXEC_I (3): alusrc_a=01, alusrc_b=01, aluop=001 → ALU_WB.
- MEM_ADDR (4): alusrc_a=01, alusrc_b=01. Load: aluop=010 → MEM_RD. Store: aluop=011 → MEM_WR.
- MEM_RD (5): mem_read=1, iord=1. Advance to MEM_WB on mem_ready, else hold.
- MEM_WB (6): reg_write=1, memtoreg=01, instr_done=1 → FETCH.
- MEM_WR (7): mem_write=1, iord=1. On mem_ready: instr_done=1 → FETCH. Else hold.
- BRANCH (8): alusrc_a=01, alusrc_b=00, aluop=100, pc_src=01, pc_write=zero, instr_done=1 → FETCH.
- JAL (9): reg_write=1, memtoreg=10, pc_src=01, pc_write=1, instr_done=1 → FETCH. Register file writes the old PC (=PC+4) at the same edge the PC loads the target.
- LUI (10): alusrc_a=10, alusrc_b=01, aluop=110 → ALU_WB.
- ALU_WB (11): reg_write=1, memtoreg=00, instr_done=1 → FETCH.
- TRAP (12): all strobes 0. Stays in TRAP until rst.
- Watchdog:
  - Counter increments each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready=0: bus_error←1, state←TRAP next cycle, request dropped.
  - mem_ready=1 in the same cycle the count would hit the limit takes priority: the access completes.
- mem_read/mem_write stay high continuously until mem_ready is sampled. mem_ready outside memory states is ignored.
- Reset mid-access: outputs drop the same cycle rst is high; the FSM restarts at FETCH.
- Cycle counts with mem_ready tied high: R/I/LUI 4, load 5, store 4, branch 3, JAL 3.

Test Plan:
- mem_ready=1, opcode 0110011 → states 0,1,2,11. reg_write=1 only in cycle 4. instr_done pulses once. Next cycle is FETCH.
- Load 0000011 with mem_ready low 3 cycles in MEM_RD → mem_read held 4 cycles with iord=1. MEM_WB shows memtoreg=01. Total 8 cycles.
- Branch with zero=1, then zero=0 → pc_write=1, pc_src=01 in BRANCH for the first; pc_write=0 for the second. Both take 3 cycles.
- JAL → state 9 shows reg_write=1, memtoreg=10, pc_write=1, pc_src=01 in the same cycle.
- Opcode 1110011 → TRAP after DECODE, illegal=1, no strobes for 20 cycles. rst → FETCH, illegal=0.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH → bus_error=1 and TRAP after 4 wait cycles. Repeat with mem_ready rising on the 4th cycle → no error, DECODE follows.
